// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter that lets two client engines share one single-port block RAM.
// Commands are registered onto the RAM port; read data is steered back by a requester tag.
module ram_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  logic ptr;  // requester that wins a tie
  logic gnt0, gnt1, xfer;
  cmd_t sel;

  logic [RD_LAT:0] vld_pipe;
  logic [RD_LAT:0] id_pipe;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!sys_rst) begin
      if (req0 && (!req1 || !ptr)) gnt0 = 1'b1;
      else if (req1)               gnt1 = 1'b1;
    end
  end

  assign ack0 = gnt0;
  assign ack1 = gnt1;
  assign xfer = gnt0 | gnt1;

  always_comb begin
    sel = '{we: we0, addr: addr0, wdata: wdata0};
    if (gnt1) sel = '{we: we1, addr: addr1, wdata: wdata1};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ptr <= 1'b0;
    end else if (xfer) begin
      ptr <= gnt0;
    end
  end

  // RAM port: address/data hold when idle so the RAM sees a quiet bus
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else if (xfer) begin
      ram_en      <= 1'b1;
      ram_we      <= sel.we;
      ram_addr    <= sel.addr;
      ram_wr_data <= sel.wdata;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
    end
  end

  // Stage k of the tag pipe is live k+1 cycles after the handshake;
  // the last stage lines up with valid douta.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= xfer && !sel.we;
      id_pipe[0]  <= gnt1;
      for (int k = 1; k <= RD_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= vld_pipe[RD_LAT] && !id_pipe[RD_LAT];
      rvalid1 <= vld_pipe[RD_LAT] &&  id_pipe[RD_LAT];
      if (vld_pipe[RD_LAT] && !id_pipe[RD_LAT]) rdata0 <= ram_rd_data;
      if (vld_pipe[RD_LAT] &&  id_pipe[RD_LAT]) rdata1 <= ram_rd_data;
    end
  end

endmodule
